mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/load_ext.sv | 39 +++
 rtl/mem_wb_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default datapath/register-address
// widths and the write-back result-source and load-size encodings.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

endpackage

// File: rtl/load_ext.sv
// Load aligner/extender: picks the addressed byte or halfword out of the
// read word, sign- or zero-extends it, and flags misaligned accesses.
// Purely combinational; the stage register lives in mem_wb_stage.
module load_ext #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data,
    output logic            misalign
);
    import riscv_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, extend it, and detect misalignment
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        data     = '0;
        misalign = 1'b0;
        case (mem_size_e'(size))
            SZ_BYTE: data = {{(XLEN-8){~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: begin
                data     = {{(XLEN-16){~uns & half_sel[15]}}, half_sel};
                misalign = off[0];
            end
            SZ_WORD: begin
                data     = rdata;
                misalign = (off != 2'b00);
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: extracts load data, captures the write-back
// result one cycle before the register-file write, and holds on stall.
// Optional retired-instruction counter enabled by macro MEM_WB_INSTRET_EN;
// without it instret_o is tied to 0.
module mem_wb_stage #(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int RADDR_W = riscv_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic               reg_write_i,
    input  logic [1:0]         result_src_i,
    input  logic [1:0]         mem_size_i,
    input  logic               mem_unsigned_i,
    input  logic [1:0]         byte_off_i,
    input  logic [XLEN-1:0]    alu_result_i,
    input  logic [XLEN-1:0]    pc_plus4_i,
    input  logic [XLEN-1:0]    mem_rdata_i,
    output logic [RADDR_W-1:0] A3,
    output logic [XLEN-1:0]    WD3,
    output logic               WE3,
    output logic               misalign_o,
    output logic [31:0]        instret_o
);
    import riscv_pkg::*;

    logic [XLEN-1:0]    ld_data;
    logic               ld_misalign;
    logic               is_load;
    logic [XLEN-1:0]    wd_next;

    logic               valid_q;
    logic               reg_write_q;
    logic               misalign_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    wd_q;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata    (mem_rdata_i),
        .size     (mem_size_i),
        .uns      (mem_unsigned_i),
        .off      (byte_off_i),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    assign is_load = (result_src_i == RES_MEM);

    // Choose the write-back value before it is registered; reserved source gives 0
    always_comb begin
        wd_next = '0;
        case (result_src_e'(result_src_i))
            RES_ALU: wd_next = alu_result_i;
            RES_MEM: wd_next = ld_data;
            RES_PC4: wd_next = pc_plus4_i;
            default: wd_next = '0;
        endcase
    end

    // Stage register: stall holds everything, flush inserts a bubble, else capture
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            misalign_q  <= 1'b0;
            rd_q        <= '0;
            wd_q        <= '0;
        end else if (!stall_i) begin
            if (flush_i) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                misalign_q  <= 1'b0;
            end else begin
                valid_q     <= valid_i;
                reg_write_q <= reg_write_i;
                misalign_q  <= valid_i & is_load & ld_misalign;
                rd_q        <= rd_i;
                wd_q        <= wd_next;
            end
        end
    end

    assign A3         = rd_q;
    assign WD3        = wd_q;
    assign misalign_o = misalign_q;
    // Repeating the write while stalled is harmless: same address, same data
    assign WE3        = valid_q & reg_write_q & (rd_q != '0) & ~misalign_q;

`ifdef MEM_WB_INSTRET_EN
    logic [31:0] instret_q;

    // Count an instruction when it leaves the stage valid and aligned; wraps naturally
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            instret_q <= '0;
        end else if (!stall_i && valid_q && !misalign_q) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = 32'd0;
`endif

endmodule
